// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digit outputs are registered and only change on a completed conversion or reset.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [3:0]       thousands_o,
  output logic [3:0]       hundreds_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       units_o
);

  localparam int unsigned NDIG  = 5;
  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SH_W  = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SH_W-1:0]    shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         th_q, th_d, hu_q, hu_d, te_q, te_d, un_q, un_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      th_q    <= '0;
      hu_q    <= '0;
      te_q    <= '0;
      un_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      th_q    <= th_d;
      hu_q    <= hu_d;
      te_q    <= te_d;
      un_q    <= un_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state, add-3 correction and shift, result capture
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    th_d    = th_q;
    hu_d    = hu_q;
    te_d    = te_q;
    un_d    = un_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, shreg_q} << 1;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CONVERT;
          shreg_d = bin_i;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
        end
      end
      ST_CONVERT: begin
        bcd_d   = shifted[SH_W-1:BIN_W];
        shreg_d = shifted[BIN_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        // A nonzero ten-thousands digit saturates the display to 9999
        if (bcd_q[19:16] != 4'd0) begin
          ovf_d = 1'b1;
          th_d  = 4'd9;
          hu_d  = 4'd9;
          te_d  = 4'd9;
          un_d  = 4'd9;
        end else begin
          ovf_d = 1'b0;
          th_d  = bcd_q[15:12];
          hu_d  = bcd_q[11:8];
          te_d  = bcd_q[7:4];
          un_d  = bcd_q[3:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign thousands_o = th_q;
  assign hundreds_o  = hu_q;
  assign tens_o      = te_q;
  assign units_o     = un_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W = 14;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [BIN_W-1:0] bin_i;
  logic             busy_o, done_o, ovf_o;
  logic [3:0]       thousands_o, hundreds_o, tens_o, units_o;
  logic [16:0]      got_w;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .bin_i       (bin_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .thousands_o (thousands_o),
    .hundreds_o  (hundreds_o),
    .tens_o      (tens_o),
    .units_o     (units_o)
  );

  always #5 clk_i = ~clk_i;

  assign got_w = {ovf_o, thousands_o, hundreds_o, tens_o, units_o};

  // Expected {ovf, thousands, hundreds, tens, units} from plain decimal arithmetic
  function automatic logic [16:0] model(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {1'(v > 9999), 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one conversion; lat is the sample index of done_o (0 if it never came)
  task automatic convert(input int unsigned v, output int lat, output int busy_n,
                         output logic [16:0] res);
    start_i = 1'b1;
    bin_i   = BIN_W'(v);
    lat     = 0;
    busy_n  = 0;
    res     = 'x;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start_i = 1'b0;
      if (busy_o) busy_n++;
      if (done_o) begin
        lat = k;
        res = got_w;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    bin_i   = '0;
    tick();
    n_tests++;
    if (got_w !== 17'd0) begin
      n_fail++; $display("FAIL reset_digits: got %h want 0", got_w);
    end
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy_o, done_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bn;
    logic [16:0] res;
    convert(0, lat, bn, res);
    n_tests++;
    if (res !== model(0)) begin
      n_fail++; $display("FAIL zero_result: got %h want %h", res, model(0));
    end
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL zero_latency: got %0d want 16", lat);
    end
    tick();
    n_tests++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL done_single_cycle: got %b want 0", done_o);
    end
  endtask

  task automatic test_basic();
    int unsigned vals [2] = '{1234, 9999};
    int lat, bn;
    logic [16:0] res;
    foreach (vals[i]) begin
      convert(vals[i], lat, bn, res);
      n_tests++;
      if (res !== model(vals[i])) begin
        n_fail++; $display("FAIL basic_%0d: got %h want %h", vals[i], res, model(vals[i]));
      end
      n_tests++;
      if (bn !== 15) begin
        n_fail++; $display("FAIL busy_len_%0d: got %0d want 15", vals[i], bn);
      end
      n_tests++;
      if (lat !== 16) begin
        n_fail++; $display("FAIL latency_%0d: got %0d want 16", vals[i], lat);
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned vals [3] = '{10000, 16383, 42};
    int lat, bn;
    logic [16:0] res;
    foreach (vals[i]) begin
      convert(vals[i], lat, bn, res);
      n_tests++;
      if (res !== model(vals[i])) begin
        n_fail++; $display("FAIL ovf_%0d: got %h want %h", vals[i], res, model(vals[i]));
      end
    end
  endtask

  task automatic test_random();
    int unsigned v;
    int lat, bn;
    logic [16:0] res;
    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, (1 << BIN_W) - 1);
      convert(v, lat, bn, res);
      n_tests++;
      if (res !== model(v)) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", v, res, model(v));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [16:0] prev, res;
    int ndone, unstable;
    prev     = got_w;
    ndone    = 0;
    unstable = 0;
    res      = 'x;
    start_i  = 1'b1;
    bin_i    = BIN_W'(567);
    for (int k = 1; k <= 40; k++) begin
      tick();
      start_i = (k == 4);
      if (k == 4) bin_i = BIN_W'(8888);
      if (done_o) begin
        ndone++;
        if (ndone == 1) res = got_w;
      end else if (ndone == 0 && got_w !== prev) begin
        unstable++;
      end
    end
    start_i = 1'b0;
    n_tests++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL hold_until_done: %0d changed samples want 0", unstable);
    end
    n_tests++;
    if (ndone !== 1) begin
      n_fail++; $display("FAIL ignore_start_pulses: got %0d want 1", ndone);
    end
    n_tests++;
    if (res !== model(567)) begin
      n_fail++; $display("FAIL ignore_start_result: got %h want %h", res, model(567));
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bn;
    logic [16:0] res;
    start_i = 1'b1;
    bin_i   = BIN_W'(4321);
    tick();
    start_i = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (got_w !== 17'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: digits=%h busy=%b done=%b want 0 0 0",
                         got_w, busy_o, done_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_o) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", ndone);
    end
    convert(4321, lat, bn, res);
    n_tests++;
    if (res !== model(4321)) begin
      n_fail++; $display("FAIL restart_result: got %h want %h", res, model(4321));
    end
  endtask

  task automatic test_back_to_back();
    int idx, cyc, last;
    idx     = 0;
    cyc     = 0;
    last    = 0;
    start_i = 1'b1;
    bin_i   = '0;
    for (int k = 0; k < 21 * 16 + 40; k++) begin
      tick();
      cyc++;
      if (done_o) begin
        n_tests++;
        if (got_w !== model(idx)) begin
          n_fail++; $display("FAIL b2b_result_%0d: got %h want %h", idx, got_w, model(idx));
        end
        n_tests++;
        if (cyc - last !== 16) begin
          n_fail++; $display("FAIL b2b_period_%0d: got %0d want 16", idx, cyc - last);
        end
        last = cyc;
        idx++;
        if (idx > 20) break;
        bin_i = BIN_W'(idx);
      end
    end
    start_i = 1'b0;
    n_tests++;
    if (idx !== 21) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 21", idx);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_overflow();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
